// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM encodings and default operand width.
package mult_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sign_mag_conv.sv
// Converts one operand to an unsigned magnitude plus sign bit; in unsigned mode the sign is 0.
module sign_mag_conv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] operand,
    input  logic             signed_mode,
    output logic [WIDTH-1:0] mag,
    output logic             sign
);

    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    assign sign = signed_mode & operand[WIDTH-1];
    assign mag  = sign ? (~operand + 1'b1) : operand;

endmodule

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one iteration per clock, WIDTH iterations per result, start/done handshake.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [PW:0]      acc_reg;
    logic             neg_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [PW-1:0]    product_reg;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH:0]   sum_next;
    logic [PW:0]      acc_next;
    logic [PW-1:0]    result_next;

    sign_mag_conv #(.WIDTH(WIDTH)) u_conv_a (
        .operand     (a),
        .signed_mode (signed_mode),
        .mag         (mag_a),
        .sign        (sign_a)
    );

    sign_mag_conv #(.WIDTH(WIDTH)) u_conv_b (
        .operand     (b),
        .signed_mode (signed_mode),
        .mag         (mag_b),
        .sign        (sign_b)
    );

    // Accumulator layout is {carry, high half, low half}; the multiplier magnitude starts in the
    // low half and is consumed from bit 0 as the partial product shifts in from the top.
    always_comb begin
        sum_next    = acc_reg[PW:WIDTH] + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
        acc_next    = {1'b0, sum_next, acc_reg[WIDTH-1:1]};
        result_next = neg_reg ? (~acc_next[PW-1:0] + 1'b1) : acc_next[PW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            mcand_reg   <= '0;
            acc_reg     <= '0;
            neg_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_reg <= mag_a;
                        acc_reg   <= {{(WIDTH + 1){1'b0}}, mag_b};
                        neg_reg   <= sign_a ^ sign_b;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= CALC;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                CALC: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        product_reg <= result_next;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        cnt_reg     <= '0;
                        state_reg   <= DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised self-checking bench for seq_multiplier at WIDTH = 4 and WIDTH = 8 against an integer model.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start4 = 1'b0, sm4 = 1'b0, busy4, done4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  product4;

    logic        start8 = 1'b0, sm8 = 1'b0, busy8, done8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] product8;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] prev4 = '0;
    logic [15:0] prev8 = '0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .signed_mode(sm4), .busy(busy4), .done(done4), .product(product4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .signed_mode(sm8), .busy(busy8), .done(done8), .product(product8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference: interpret operands as integers and multiply, keep 2*w bits.
    function automatic logic [15:0] ref_mul(input int w, input logic [7:0] x, input logic [7:0] y,
                                            input bit sm);
        longint ix, iy, p;
        ix = longint'(x);
        iy = longint'(y);
        if (sm && x[w-1]) ix = ix - (longint'(1) << w);
        if (sm && y[w-1]) iy = iy - (longint'(1) << w);
        p = ix * iy;
        return 16'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic drive_in(input int w, input logic [7:0] x, input logic [7:0] y,
                            input bit sm, input bit st);
        if (w == 4) begin
            a4 = x[3:0]; b4 = y[3:0]; sm4 = sm; start4 = st;
        end else begin
            a8 = x; b8 = y; sm8 = sm; start8 = st;
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 4) ? done4 : done8;
    endfunction

    function automatic logic [15:0] get_product(input int w);
        return (w == 4) ? {8'h00, product4} : product8;
    endfunction

    function automatic logic [7:0] rand_op(input int w);
        return 8'($urandom_range(0, (1 << w) - 1));
    endfunction

    // Launches one operation on the next edge; returns #1 after the edge that should raise done.
    task automatic run_op(input int w, input logic [7:0] x, input logic [7:0] y,
                          input bit sm, input bit noise);
        logic [15:0] exp, prev;
        int          cyc;
        bit          got_done, busy_ok, hold_ok;
        exp = ref_mul(w, x, y, sm);
        prev = (w == 4) ? prev4 : prev8;
        drive_in(w, x, y, sm, 1'b1);
        @(posedge clk); #1;
        busy_ok = get_busy(w) && !get_done(w);
        hold_ok = (get_product(w) == prev);
        drive_in(w, x, y, sm, 1'b0);
        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < w + 4) begin
            if (noise) drive_in(w, rand_op(w), rand_op(w), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)));
            @(posedge clk); #1;
            cyc++;
            if (get_done(w)) begin
                got_done = 1'b1;
                if (get_busy(w)) busy_ok = 1'b0;
            end else begin
                if (!get_busy(w)) busy_ok = 1'b0;
                if (get_product(w) != prev) hold_ok = 1'b0;
            end
        end
        drive_in(w, x, y, sm, 1'b0);
        $display("op w=%0d a=%h b=%h signed=%0d noise=%0d -> product=%h expected=%h cycles=%0d",
                 w, x, y, sm, noise, get_product(w), exp, cyc);
        check("latency", 32'(cyc), 32'(w));
        check("busy", {31'd0, busy_ok}, 32'd1);
        check("hold", {31'd0, hold_ok}, 32'd1);
        check("product", {16'd0, get_product(w)}, {16'd0, exp});
        if (w == 4) prev4 = exp;
        else prev8 = exp;
    endtask

    // Idle cycles after an operation: done must have been a single-cycle pulse.
    task automatic idle(input int w, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == 0) check("done_pulse", {30'd0, get_done(w), get_busy(w)}, 32'd0);
        end
    endtask

    initial begin
        int w;
        bit saw_done;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {30'd0, busy4, busy8}, 32'd0);
        check("rst_done", {30'd0, done4, done8}, 32'd0);
        check("rst_product4", {24'd0, product4}, 32'd0);
        check("rst_product8", {16'd0, product8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed WIDTH = 4 cases
        run_op(4, 8'd6, 8'd3, 1'b0, 1'b0);
        idle(4, 2);
        run_op(4, 8'd13, 8'd13, 1'b0, 1'b0);
        idle(4, 1);
        run_op(4, 8'd0, 8'd0, 1'b0, 1'b0);
        idle(4, 1);
        run_op(4, 8'd15, 8'd15, 1'b0, 1'b0);
        idle(4, 1);
        run_op(4, 8'h7, 8'hC, 1'b1, 1'b0);
        idle(4, 1);
        run_op(4, 8'h8, 8'h8, 1'b1, 1'b0);
        idle(4, 1);
        run_op(4, 8'hF, 8'h1, 1'b1, 1'b0);
        idle(4, 1);

        // Operand/start changes during CALC, then back-to-back starts straight out of DONE
        run_op(4, 8'h9, 8'h5, 1'b0, 1'b1);
        run_op(4, 8'hA, 8'h3, 1'b1, 1'b0);
        run_op(4, 8'h5, 8'hB, 1'b0, 1'b1);
        idle(4, 1);

        for (int i = 0; i < 24; i++) begin
            run_op(4, rand_op(4), rand_op(4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) idle(4, $urandom_range(1, 2));
        end
        idle(4, 1);

        // WIDTH = 8 instance
        run_op(8, 8'hFF, 8'hFF, 1'b0, 1'b0);
        idle(8, 1);
        run_op(8, 8'h80, 8'h7F, 1'b1, 1'b0);
        idle(8, 1);
        for (int i = 0; i < 12; i++) begin
            run_op(8, rand_op(8), rand_op(8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) != 0) idle(8, 1);
        end
        idle(8, 1);

        // Asynchronous reset in the middle of CALC
        drive_in(4, 8'hD, 8'h7, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive_in(4, 8'hD, 8'h7, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy4}, 32'd0);
        check("arst_done", {31'd0, done4}, 32'd0);
        check("arst_product4", {24'd0, product4}, 32'd0);
        check("arst_product8", {16'd0, product8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev4 = '0;
        prev8 = '0;
        saw_done = 1'b0;
        w = 4;
        repeat (w + 4) begin
            @(posedge clk); #1;
            if (done4 || busy4) saw_done = 1'b1;
        end
        check("no_done_after_rst", {31'd0, saw_done}, 32'd0);

        run_op(4, 8'h3, 8'hE, 1'b1, 1'b0);
        idle(4, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
